// File: rtl/te_fifo.sv
// Time-event FIFO: synchronizes up to four event lines and timestamps their rising
// edges with a free-running counter. It queues {source, timestamp} for the host.
module te_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        host_cs,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_d4wt,
    output logic [31:0] host_d4rd,
    input  logic [3:0]  event_src,
    output logic        te_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [5:0] DEPTH_C    = 6'(DEPTH);
    localparam logic [5:0] A_CTRL     = 6'h00;
    localparam logic [5:0] A_THRESH   = 6'h01;
    localparam logic [5:0] A_STATUS   = 6'h02;
    localparam logic [5:0] A_TS       = 6'h03;
    localparam logic [5:0] A_HEAD_TS  = 6'h04;
    localparam logic [5:0] A_HEAD_SRC = 6'h05;

    logic          enable_q, enable_d;
    logic          int_enable_q, int_enable_d;
    logic [3:0]    src_enable_q, src_enable_d;
    logic [5:0]    threshold_q, threshold_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic [31:0]   ts_q, ts_d;
    logic [3:0]    s1_q, s2_q, s3_q;
    logic [3:0]    pend_q, pend_d;
    logic [31:0]   pts_q [4];
    logic [31:0]   pts_d [4];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [5:0]    count_q, count_d;
    logic [33:0]   mem_q [DEPTH];

    logic          wr_sel, flush, pop_req;
    logic          full, empty, served, push, pop, full_drop;
    logic [3:0]    edge_v, serve_oh, ovw;
    logic [1:0]    serve_idx;
    logic [2:0]    n_drop;
    logic [8:0]    drop_sum;
    logic [33:0]   head;

    assign wr_sel  = host_cs & host_wr;
    assign flush   = wr_sel & (host_addr == A_CTRL) & host_d4wt[31];
    assign pop_req = host_cs & host_rd & (host_addr == A_HEAD_SRC);

    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign edge_v[gi] = s2_q[gi] & ~s3_q[gi] & src_enable_q[gi] & enable_q;
    end

    // Lowest-index pending source wins the single push slot each cycle.
    assign serve_oh  = pend_q & (~pend_q + 4'd1);
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 6'd0);
    assign served    = |pend_q;
    assign push      = served & ~full & ~flush;
    assign full_drop = served & full & ~flush;
    assign pop       = pop_req & ~empty & ~flush;
    assign ovw       = edge_v & pend_q & ~serve_oh & {4{~flush}};

    always_comb begin
        serve_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) serve_idx = 2'(i);
        end
    end

    always_comb begin
        n_drop = {2'b0, full_drop};
        for (int i = 0; i < 4; i++) begin
            n_drop = n_drop + {2'b0, ovw[i]};
        end
        drop_sum = {1'b0, drop_count_q} + {6'd0, n_drop};
    end

    always_comb begin
        enable_d     = enable_q;
        int_enable_d = int_enable_q;
        src_enable_d = src_enable_q;
        threshold_d  = threshold_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        ts_d         = enable_q ? ts_q + 32'd1 : ts_q;
        pend_d       = pend_q & ~serve_oh;
        pts_d        = pts_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + {5'd0, push} - {5'd0, pop};

        if (wr_sel && host_addr == A_CTRL) begin
            enable_d     = host_d4wt[0];
            int_enable_d = host_d4wt[1];
            src_enable_d = host_d4wt[7:4];
        end
        if (wr_sel && host_addr == A_THRESH) threshold_d = host_d4wt[5:0];
        if (wr_sel && host_addr == A_TS) ts_d = host_d4wt;

        // A new edge on the source being served re-arms it rather than dropping.
        for (int i = 0; i < 4; i++) begin
            if (edge_v[i]) begin
                pend_d[i] = 1'b1;
                pts_d[i]  = ts_q;
            end
        end

        if (n_drop != 3'd0) begin
            overflow_d   = 1'b1;
            drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
        if (wr_sel && host_addr == A_STATUS && host_d4wt[16]) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (flush) begin
            pend_d   = 4'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            enable_q     <= 1'b0;
            int_enable_q <= 1'b0;
            src_enable_q <= 4'd0;
            threshold_q  <= 6'd0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
            ts_q         <= 32'd0;
            s1_q         <= 4'd0;
            s2_q         <= 4'd0;
            s3_q         <= 4'd0;
            pend_q       <= 4'd0;
            for (int i = 0; i < 4; i++) pts_q[i] <= 32'd0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= 6'd0;
        end else begin
            enable_q     <= enable_d;
            int_enable_q <= int_enable_d;
            src_enable_q <= src_enable_d;
            threshold_q  <= threshold_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            ts_q         <= ts_d;
            s1_q         <= event_src;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pend_q       <= pend_d;
            for (int i = 0; i < 4; i++) pts_q[i] <= pts_d[i];
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {serve_idx, pts_q[serve_idx]};
    end

    assign head   = mem_q[rd_ptr_q];
    assign te_irq = int_enable_q & (count_q >= threshold_q) & (threshold_q != 6'd0);

    always_comb begin
        host_d4rd = 32'd0;
        case (host_addr)
            A_CTRL:     host_d4rd = {24'd0, src_enable_q, 2'b00, int_enable_q, enable_q};
            A_THRESH:   host_d4rd = {26'd0, threshold_q};
            A_STATUS:   host_d4rd = {15'd0, overflow_q, drop_count_q, 2'b00, count_q};
            A_TS:       host_d4rd = ts_q;
            A_HEAD_TS:  host_d4rd = empty ? 32'd0 : head[31:0];
            A_HEAD_SRC: host_d4rd = empty ? 32'd0 : {1'b1, 29'd0, head[33:32]};
            default:    host_d4rd = 32'd0;
        endcase
    end
endmodule
